// File: rtl/mode_register_if.sv
// Bundle of the mode register's control, data and status signals.
// The master drives operation select and data; the slave (the register) reports state.
interface mode_register_if #(
  parameter int WIDTH       = 16,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
);
  logic                   reg_clear;
  logic [2:0]             reg_mode;
  logic [WIDTH-1:0]       reg_in;
  logic                   reg_serial_in;
  logic [WIDTH-1:0]       reg_out;
  logic                   reg_serial_out;
  logic [COUNT_WIDTH-1:0] reg_shift_count;
  logic                   reg_shift_done;

  modport master (
    output reg_clear, reg_mode, reg_in, reg_serial_in,
    input  reg_out, reg_serial_out, reg_shift_count, reg_shift_done
  );

  modport slave (
    input  reg_clear, reg_mode, reg_in, reg_serial_in,
    output reg_out, reg_serial_out, reg_shift_count, reg_shift_done
  );
endinterface

// File: rtl/mode_register.sv
// Multi-mode operand register for the sequential multiplier: load, shifts,
// rotates and increment, plus a saturating shift counter that marks when a
// full WIDTH of shift/rotate steps has elapsed since the last load or clear.
// Every output comes straight from a flop or a decode of one; there is no
// input-to-output combinational path.
module mode_register #(
  parameter int WIDTH       = 16,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reg_reset,
  mode_register_if.slave   bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_SRA  = 3'b011;
  localparam logic [2:0] MODE_SL   = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_INC  = 3'b111;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(WIDTH);

  logic [WIDTH-1:0]       data_q, data_d;
  logic                   serial_q, serial_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   shifting;
  logic [WIDTH:0]         inc_sum;

  assign inc_sum = {1'b0, data_q} + {{WIDTH{1'b0}}, 1'b1};

  // Next-state selection: clear overrides any mode; shift/rotate modes bump the counter.
  always_comb begin
    data_d   = data_q;
    serial_d = serial_q;
    count_d  = count_q;
    shifting = 1'b0;
    if (bus.reg_clear) begin
      data_d   = '0;
      serial_d = 1'b0;
      count_d  = '0;
    end else begin
      case (bus.reg_mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          data_d   = bus.reg_in;
          serial_d = 1'b0;
          count_d  = '0;
        end
        MODE_SRL: begin
          data_d   = {bus.reg_serial_in, data_q[WIDTH-1:1]};
          serial_d = data_q[0];
          shifting = 1'b1;
        end
        MODE_SRA: begin
          data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          serial_d = data_q[0];
          shifting = 1'b1;
        end
        MODE_SL: begin
          data_d   = {data_q[WIDTH-2:0], bus.reg_serial_in};
          serial_d = data_q[WIDTH-1];
          shifting = 1'b1;
        end
        MODE_ROR: begin
          data_d   = {data_q[0], data_q[WIDTH-1:1]};
          serial_d = data_q[0];
          shifting = 1'b1;
        end
        MODE_ROL: begin
          data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          serial_d = data_q[WIDTH-1];
          shifting = 1'b1;
        end
        MODE_INC: begin
          data_d   = inc_sum[WIDTH-1:0];
          serial_d = inc_sum[WIDTH];
        end
        default: ;
      endcase
      // Counter saturates at WIDTH; shifting itself keeps going.
      if (shifting && (count_q != COUNT_MAX)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reg_reset) begin
    if (reg_reset) begin
      data_q   <= '0;
      serial_q <= 1'b0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      serial_q <= serial_d;
      count_q  <= count_d;
    end
  end

  assign bus.reg_out         = data_q;
  assign bus.reg_serial_out  = serial_q;
  assign bus.reg_shift_count = count_q;
  assign bus.reg_shift_done  = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_mode_register.sv
// Scoreboard bench for mode_register at WIDTH = 8: the driver pushes
// hand-computed expectations after each edge, a monitor pops and compares
// on the following falling edge. Asynchronous reset is checked directly.
module tb_mode_register;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SRL  = 3'b010;
  localparam logic [2:0] SRA  = 3'b011;
  localparam logic [2:0] SL   = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] ROL  = 3'b110;
  localparam logic [2:0] INC  = 3'b111;

  typedef struct {
    string           name;
    logic [W-1:0]    out;
    logic            so;
    logic [CW-1:0]   cnt;
    logic            done;
  } exp_t;

  logic clock;
  logic reg_reset;

  mode_register_if #(.WIDTH(W), .COUNT_WIDTH(CW)) bus ();

  mode_register #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reg_reset (reg_reset),
    .bus       (bus.slave)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input exp_t e);
    n_cmp++;
    if (bus.reg_out !== e.out || bus.reg_serial_out !== e.so ||
        bus.reg_shift_count !== e.cnt || bus.reg_shift_done !== e.done) begin
      n_err++;
      $display("FAIL %s: got out=%h so=%b cnt=%0d done=%b, need out=%h so=%b cnt=%0d done=%b",
               e.name, bus.reg_out, bus.reg_serial_out, bus.reg_shift_count,
               bus.reg_shift_done, e.out, e.so, e.cnt, e.done);
    end
  endtask

  // Monitor: one expectation per falling edge after it has been queued.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      compare(exp_q.pop_front());
    end
  end

  // Drive one operation, then queue its expected post-edge state.
  task automatic step(input string name, input logic [2:0] mode, input logic [W-1:0] din,
                      input logic s, input logic clr,
                      input logic [W-1:0] e_out, input logic e_so,
                      input int e_cnt, input logic e_done);
    exp_t e;
    bus.reg_mode      = mode;
    bus.reg_in        = din;
    bus.reg_serial_in = s;
    bus.reg_clear     = clr;
    @(posedge clock);
    e.name = name; e.out = e_out; e.so = e_so; e.cnt = CW'(e_cnt); e.done = e_done;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Pulse reset between edges and check the outputs fall without a clock.
  task automatic async_reset(input string name);
    exp_t e;
    #2 reg_reset = 1'b1;
    #1;
    e.name = name; e.out = '0; e.so = 1'b0; e.cnt = '0; e.done = 1'b0;
    compare(e);
    #1 reg_reset = 1'b0;
  endtask

  logic [W-1:0] sra_v [8] = '{8'hCB, 8'hE5, 8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF};
  logic         sra_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] rol_v [8] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F};
  logic         rol_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] pre_v [5] = '{8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E};
  logic         pre_s [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    exp_t e;
    reg_reset         = 1'b1;
    bus.reg_clear     = 1'b0;
    bus.reg_mode      = HOLD;
    bus.reg_in        = '0;
    bus.reg_serial_in = 1'b0;
    #1;
    e.name = "reset_state"; e.out = '0; e.so = 1'b0; e.cnt = '0; e.done = 1'b0;
    compare(e);
    #2 reg_reset = 1'b0;
    @(negedge clock);

    // 1: async reset of a loaded value, then hold keeps zero
    step("load_a5", LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 0, 1'b0);
    async_reset("async_reset_a5");
    step("hold_after_reset", HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

    // 2: arithmetic shifts to saturation
    step("load_96", LOAD, 8'h96, 1'b1, 1'b0, 8'h96, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sra_%0d", i + 1), SRA, 8'h00, 1'b0, 1'b0,
           sra_v[i], sra_s[i], i + 1, (i == 7));
    end
    step("sra_9_saturate", SRA, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8, 1'b1);
    step("hold_keeps_serial", HOLD, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8, 1'b1);

    // 3: left shift then rotate right
    step("load_81", LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 0, 1'b0);
    step("sl_s1", SL, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1, 1'b0);
    step("ror", ROR, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 2, 1'b0);

    // 4: increment with carry out, counter untouched
    step("load_fe", LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 0, 1'b0);
    step("inc_1", INC, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 0, 1'b0);
    step("inc_2_carry", INC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0);

    // 5: logical shifts with serial in, then clear beats mode
    step("load_3c", LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 0, 1'b0);
    step("srl_1", SRL, 8'h00, 1'b1, 1'b0, 8'h9E, 1'b0, 1, 1'b0);
    step("srl_2", SRL, 8'h00, 1'b1, 1'b0, 8'hCF, 1'b0, 2, 1'b0);
    step("srl_3", SRL, 8'h00, 1'b1, 1'b0, 8'hE7, 1'b1, 3, 1'b0);
    step("clear_vs_srl", SRL, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 0, 1'b0);

    // 6: reset in the middle of rotates, then a full rotate cycle
    step("load_f0", LOAD, 8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("rol_pre_%0d", i + 1), ROL, 8'h00, 1'b0, 1'b0,
           pre_v[i], pre_s[i], i + 1, 1'b0);
    end
    async_reset("async_reset_mid");
    step("load_0f", LOAD, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("rol_%0d", i + 1), ROL, 8'h00, 1'b0, 1'b0,
           rol_v[i], rol_s[i], i + 1, (i == 7));
    end

    bus.reg_mode = HOLD;
    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mode_register.md
# mode_register

Parametrised multi-mode data register for the sequential multiplicator datapath. It supports:

- parallel load;
- logical and arithmetic right shift, and left shift, with serial input;
- rotates and increment;
- a shift counter that flags when WIDTH shift/rotate operations have completed since the last load.

It holds the multiplier/partial-product operands, so the controller no longer needs a separate bit counter.

## Interface

Parameters:
- WIDTH, 16, data width in bits (≥ 2)
- COUNT_WIDTH, $clog2(WIDTH+1), width of shift counter

Ports:
- clock  input  1  rising-edge clock
- reg_reset  input  1  asynchronous, active-high reset
- reg_clear  input  1  synchronous clear; highest synchronous priority
- reg_mode  input  3  operation select, sampled each rising edge
- reg_in  input  WIDTH  parallel load data
- reg_serial_in  input  1  bit shifted into vacated position
- reg_out  output  WIDTH  register contents
- reg_serial_out  output  COUNT_WIDTH→1  registered bit lost by last shift, or increment carry
- reg_shift_count  output  COUNT_WIDTH  shift/rotate operations since last load/clear, saturating
- reg_shift_done  output  1  high when reg_shift_count == WIDTH

## Operation

Reset (reg_reset = 1, asynchronous):
- reg_out = 0
- reg_serial_out = 0
- reg_shift_count = 0
- reg_shift_done = 0

Priority per edge: reg_reset > reg_clear > reg_mode.
- reg_clear = 1: reg_out, reg_serial_out and reg_shift_count go to 0, regardless of reg_mode.

reg_mode encoding (let Q = reg_out, s = reg_serial_in):
- 000 hold: all state unchanged.
- 001 load:
  - Q ← reg_in
  - count ← 0
  - serial_out ← 0
- 010 SRL: Q ← {s, Q[WIDTH-1:1]}; serial_out ← Q[0].
- 011 SRA: Q ← {Q[WIDTH-1], Q[WIDTH-1:1]}; serial_out ← Q[0]. s is ignored.
- 100 SL: Q ← {Q[WIDTH-2:0], s}; serial_out ← Q[WIDTH-1].
- 101 ROR: Q ← {Q[0], Q[WIDTH-1:1]}; serial_out ← Q[0].
- 110 ROL: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}; serial_out ← Q[WIDTH-1].
- 111 INC:
  - Q ← Q + 1 modulo 2^WIDTH
  - serial_out ← carry out (1 only when Q was all ones)
  - count unchanged

Shift counter:
- Modes 010–110 increment count by 1, saturating at WIDTH.
- Shifting continues after saturation; count stays at WIDTH.
- reg_shift_done is a pure decode of the count register, so it is effectively registered.

## Timing

- All operations take effect on the rising edge in which they are sampled. reg_out reflects the result one cycle later (latency 1).
- No combinational path from any input to any output.
- reg_shift_done rises in the same cycle that reg_shift_count becomes WIDTH.
- reg_shift_done stays high until the next load, clear or reset.
- reg_reset asserted mid-sequence:
  - outputs go to 0 immediately, without waiting for a clock edge;
  - on deassertion, the first rising edge executes the sampled mode normally.
- Load and shift are mutually exclusive by encoding. There is no simultaneous-event case other than clear vs. mode, where clear wins.
- Hold (000) does not change reg_serial_out. It keeps the last shifted-out or carry bit.

## Test plan

WIDTH = 8 for all scenarios.

1. Reset: assert reg_reset between edges, with reg_out = 8'hA5 beforehand.
   - Required: reg_out, reg_serial_out and reg_shift_count are 0 before the next edge.
   - Required: mode 000 after release holds 0.
2. Load 8'h96, then 8 × SRA.
   - Expected sequence: 8'hCB, E5, F2, F9, FC, FE, FF, FF.
   - serial_out sequence: 0,1,1,0,1,0,0,1.
   - reg_shift_done rises on the 8th shift (count = 8).
   - A 9th shift keeps count = 8.
3. Load 8'h81, then SL with serial_in = 1.
   - Required: reg_out = 8'h03, serial_out = 1.
   - Then ROR: reg_out = 8'h81, serial_out = 1, count = 2.
4. Load 8'hFE, then INC twice.
   - After the first INC: 8'hFF, serial_out = 0.
   - After the second INC: 8'h00, serial_out = 1.
   - Count remains 0.
5. Load 8'h3C, then 3 × SRL with serial_in = 1.
   - Required: reg_out = 8'hE7, count = 3.
   - Then mode 010 together with reg_clear = 1: reg_out = 0, count = 0, serial_out = 0.
6. Reset mid-sequence: load 8'hF0, 5 × ROL, assert reg_reset for a partial cycle.
   - Required: all outputs are 0 asynchronously.
   - Then load 8'h0F followed by 8 × ROL: reg_out = 8'h0F with done = 1.
